// File: rtl/edge_best_sel_if.sv
// rtl/edge_best_sel_if.sv - candidate-in / result-out stream bundle for edge_best_sel
interface edge_best_sel_if #(
  parameter int VW = 7,
  parameter int DW = 25,
  parameter int EW = 31,
  parameter int IW = 16
);
  localparam int SW = ((DW > EW) ? DW : EW) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_dest;
  logic [DW-1:0] in_dv;
  logic [EW-1:0] in_w;
  logic          in_upd;
  logic [IW-1:0] in_id;
  logic          in_last;

  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_dest;
  logic [IW-1:0] out_id;
  logic [SW-1:0] out_score;
  logic          out_found;
  logic          out_last;

  modport master (
    output in_valid, in_dest, in_dv, in_w, in_upd, in_id, in_last, out_ready,
    input  in_ready, out_valid, out_dest, out_id, out_score, out_found, out_last
  );

  modport slave (
    input  in_valid, in_dest, in_dv, in_w, in_upd, in_id, in_last, out_ready,
    output in_ready, out_valid, out_dest, out_id, out_score, out_found, out_last
  );
endinterface

// File: rtl/edge_best_sel.sv
// rtl/edge_best_sel.sv - per-destination best-edge reduction with frame-end drain
module edge_best_sel #(
  parameter int VW = 7,
  parameter int DW = 25,
  parameter int EW = 31,
  parameter int IW = 16,
  parameter int NV = 128
) (
  input  logic            clk,
  input  logic            reset_n,
  edge_best_sel_if.slave  bus,
  output logic            err_range
);
  localparam int SW = ((DW > EW) ? DW : EW) + 1;
  localparam int TW = (NV > 1) ? $clog2(NV) : 1;
  localparam logic [VW:0]   NV_LIM   = (VW+1)'(NV);
  localparam logic [TW-1:0] LAST_IDX = TW'(NV - 1);

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;

  logic          s1_valid, s1_upd, s1_nz;
  logic [TW-1:0] s1_idx;
  logic [SW-1:0] s1_score;
  logic [IW-1:0] s1_id;

  logic [NV-1:0] t_found, t_upd;
  logic [SW-1:0] t_score [NV];
  logic [IW-1:0] t_id    [NV];

  logic [TW-1:0] ptr, out_idx;
  logic accept, in_range, c_win, load, out_hs, drain_done;

  // Gating with reset_n keeps in_ready low while reset is held.
  assign bus.in_ready = reset_n && (state_q == ACCUM);
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_range     = {1'b0, bus.in_dest} < NV_LIM;
  assign out_hs       = bus.out_valid && bus.out_ready;
  assign drain_done   = out_hs && bus.out_last;
  assign load         = (state_q == DRAIN) && !(bus.out_valid && (bus.out_last || !bus.out_ready));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && bus.in_last) state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Candidate vs incumbent: non-edge loses, empty slot accepts, update flag dominates, then strict score.
  always_comb begin
    c_win = 1'b0;
    if (!s1_nz)                       c_win = 1'b0;
    else if (!t_found[s1_idx])        c_win = 1'b1;
    else if (s1_upd != t_upd[s1_idx]) c_win = s1_upd;
    else                              c_win = s1_score < t_score[s1_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      err_range <= 1'b0;
    end else begin
      s1_valid <= accept && in_range;
      if (accept && !in_range) err_range <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_idx   <= bus.in_dest[TW-1:0];
      s1_score <= SW'(bus.in_dv) + SW'(bus.in_w);
      s1_upd   <= bus.in_upd;
      s1_nz    <= |bus.in_w;
      s1_id    <= bus.in_id;
    end
  end

  // Commits only happen in ACCUM/FLUSH and clears only in DRAIN, so the two never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_found <= '0;
    end else begin
      if (s1_valid && c_win) t_found[s1_idx] <= 1'b1;
      if (out_hs)            t_found[out_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid && c_win) begin
      t_upd[s1_idx]   <= s1_upd;
      t_score[s1_idx] <= s1_score;
      t_id[s1_idx]    <= s1_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_dest  <= '0;
      bus.out_id    <= '0;
      bus.out_score <= '0;
      bus.out_found <= 1'b0;
      bus.out_last  <= 1'b0;
      ptr           <= '0;
      out_idx       <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_dest  <= VW'(ptr);
      bus.out_found <= t_found[ptr];
      bus.out_id    <= t_found[ptr] ? t_id[ptr] : '0;
      bus.out_score <= t_found[ptr] ? t_score[ptr] : '0;
      bus.out_last  <= (ptr == LAST_IDX);
      out_idx       <= ptr;
      ptr           <= (ptr == LAST_IDX) ? '0 : ptr + TW'(1);
    end else if (out_hs) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_edge_best_sel.sv
// tb/tb_edge_best_sel.sv - frame vectors and corner sequences for edge_best_sel
module tb_edge_best_sel;
  localparam int VW = 7, DW = 25, EW = 31, IW = 16, NV = 4, SW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_range;
  always #5 clk = ~clk;

  edge_best_sel_if #(.VW(VW), .DW(DW), .EW(EW), .IW(IW)) bus ();

  edge_best_sel #(.VW(VW), .DW(DW), .EW(EW), .IW(IW), .NV(NV)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .err_range(err_range)
  );

  typedef struct packed {
    logic [VW-1:0] dest; logic [DW-1:0] dv; logic [EW-1:0] w; logic upd; logic [IW-1:0] id;
  } cand_t;
  typedef struct packed { logic found; logic [SW-1:0] score; logic [IW-1:0] id; } res_t;
  typedef struct packed { logic [2:0] n; cand_t [3:0] c; res_t [NV-1:0] e; } vec_t;
  typedef struct packed {
    logic [VW-1:0] dest; logic found; logic [SW-1:0] score; logic [IW-1:0] id; logic last;
  } out_t;

  out_t exp_q [$];
  vec_t vt [5];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b1;
  int   pat [4] = '{1, 0, 0, 1};
  out_t got, want;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic cand_t mk(int d, int dv, int w, int u, int id);
    cand_t c;
    c.dest = VW'(d); c.dv = DW'(dv); c.w = EW'(w); c.upd = u[0]; c.id = IW'(id);
    return c;
  endfunction

  function automatic res_t rs(int f, int score, int id);
    res_t r;
    r.found = f[0]; r.score = SW'(score); r.id = IW'(id);
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      got = {bus.out_dest, bus.out_found, bus.out_score, bus.out_id, bus.out_last};
      if (exp_q.size() == 0) begin
        fail_timeout("unexpected_result");
      end else begin
        want = exp_q.pop_front();
        check($sformatf("drain_entry%0d", want.dest), 64'(got), 64'(want));
      end
    end
  end

  task automatic push_frame(input res_t [NV-1:0] e);
    for (int d = 0; d < NV; d++)
      exp_q.push_back(out_t'({VW'(d), e[d].found, e[d].score, e[d].id, (d == NV - 1)}));
  endtask

  task automatic send(input cand_t c, input logic last);
    int k;
    bus.in_valid = 1'b1; bus.in_dest = c.dest; bus.in_dv = c.dv; bus.in_w = c.w;
    bus.in_upd = c.upd; bus.in_id = c.id; bus.in_last = last;
    k = 0;
    while (!bus.in_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.in_ready) fail_timeout("in_ready_wait");
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && bus.in_ready) && k < 100) begin @(posedge clk); #1; k++; end
    if (!(exp_q.size() == 0 && bus.in_ready)) fail_timeout("drain_complete");
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!bus.out_valid && k < 50) begin @(posedge clk); #1; k++; end
    if (!bus.out_valid) fail_timeout(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] snap, cur;
    logic        prev_ready, prev_valid;
    res_t [NV-1:0] e;
    int k;

    bus.in_valid = 1'b0; bus.in_dest = '0; bus.in_dv = '0; bus.in_w = '0;
    bus.in_upd = 1'b0; bus.in_id = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

    for (int v = 0; v < 5; v++) vt[v] = '0;
    vt[0].n = 1; vt[0].c[0] = mk(2, 10, 5, 0, 7);
    vt[0].e[2] = rs(1, 15, 7);
    vt[1].n = 3; vt[1].c[0] = mk(1, 10, 5, 0, 1); vt[1].c[1] = mk(1, 3, 4, 0, 2);
    vt[1].c[2] = mk(1, 2, 5, 0, 3);
    vt[1].e[1] = rs(1, 7, 2);
    vt[2].n = 2; vt[2].c[0] = mk(0, 1, 1, 0, 1); vt[2].c[1] = mk(0, 100, 100, 1, 2);
    vt[2].e[0] = rs(1, 200, 2);
    vt[3].n = 3; vt[3].c[0] = mk(3, 5, 0, 0, 9); vt[3].c[1] = mk(2, 4, 4, 0, 5);
    vt[3].c[2] = mk(2, 1, 0, 0, 6);
    vt[3].e[2] = rs(1, 8, 5);
    vt[4].n = 4; vt[4].c[0] = mk(1, 1, 1, 0, 10); vt[4].c[1] = mk(1, 50, 1, 1, 11);
    vt[4].c[2] = mk(1, 20, 1, 1, 12); vt[4].c[3] = mk(0, 3, 3, 0, 13);
    vt[4].e[1] = rs(1, 21, 12); vt[4].e[0] = rs(1, 6, 13);

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_err_range", err_range, 0);
    check("reset_out_fields", {bus.out_dest, bus.out_id, bus.out_score, bus.out_found, bus.out_last}, 0);
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", bus.in_ready, 1);
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      push_frame(vt[v].e);
      for (int i = 0; i < int'(vt[v].n); i++) send(vt[v].c[i], i == int'(vt[v].n) - 1);
      wait_idle();
    end
    check("err_range_clean", err_range, 0);

    // Out-of-range candidate with last still ends the frame on the normal schedule.
    push_frame('0);
    send(mk(5, 1, 1, 0, 33), 1'b1);
    check("range_flush_ready", bus.in_ready, 0);
    check("err_range_set", err_range, 1);
    @(posedge clk); #1;
    check("drain_t1_idle", bus.out_valid, 0);
    @(posedge clk); #1;
    check("drain_t2_valid", bus.out_valid, 1);
    check("drain_t2_dest", bus.out_dest, 0);
    wait_idle();
    check("err_range_sticky", err_range, 1);

    // Stalled drain: outputs must hold while out_ready is low.
    bus.out_ready = 1'b0;
    e = '0; e[1] = rs(1, 3, 3);
    push_frame(e);
    send(mk(1, 1, 2, 0, 3), 1'b1);
    wait_valid("stall_valid_wait");
    snap = {bus.out_valid, bus.out_dest, bus.out_id, bus.out_score, bus.out_found, bus.out_last};
    check("stall_first_dest", bus.out_dest, 0);
    repeat (2) @(posedge clk);
    #1;
    check("stall_hold", {bus.out_valid, bus.out_dest, bus.out_id, bus.out_score, bus.out_found, bus.out_last}, snap);
    k = 0;
    while (!(exp_q.size() == 0 && bus.in_ready) && k < 100) begin
      prev_ready = pat[k % 4][0];
      prev_valid = bus.out_valid;
      bus.out_ready = prev_ready;
      snap = {bus.out_valid, bus.out_dest, bus.out_id, bus.out_score, bus.out_found, bus.out_last};
      @(posedge clk); #1;
      cur = {bus.out_valid, bus.out_dest, bus.out_id, bus.out_score, bus.out_found, bus.out_last};
      if (!prev_ready && prev_valid) check("stall_hold_pattern", cur, snap);
      k++;
    end
    if (!(exp_q.size() == 0 && bus.in_ready)) fail_timeout("stall_drain");
    bus.out_ready = 1'b1;

    // Reset mid-drain discards the frame and the pending entry 2.
    e = '0; e[2] = rs(1, 15, 9);
    push_frame(e);
    send(mk(2, 10, 5, 0, 9), 1'b1);
    k = 0;
    while (!(bus.out_valid && bus.out_dest == 1) && k < 50) begin @(posedge clk); #1; k++; end
    if (!(bus.out_valid && bus.out_dest == 1)) fail_timeout("mid_drain_wait");
    reset_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check("reset_mid_out_valid", bus.out_valid, 0);
    check("reset_mid_in_ready", bus.in_ready, 0);
    exp_q.delete();
    #2;
    reset_n = 1'b1;
    #1;
    check("ready_after_mid_reset", bus.in_ready, 1);
    check("err_range_cleared", err_range, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    push_frame('0);
    send(mk(3, 7, 0, 0, 4), 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_best_sel.md
# edge_best_sel

Streaming per-destination best-edge selector for the Bellman-Ford relaxation path. It accepts a frame of candidate edges, keeps the best candidate for each destination vertex in a register table, and drains one result per vertex at frame end. It generalises the two-edge pairwise comparator into a parametrised, pipelined reduction over arbitrarily many edges. The selection rules (non-edge, update-flag priority) are unchanged from the pairwise comparator.

## Interface
Parameters:
- VW, 7: vertex index width
- DW, 25: destination-vertex distance width
- EW, 31: edge weight magnitude width (weight 0 = non-edge)
- IW, 16: edge identifier width
- NV, 128: number of vertices/table entries (NV <= 2**VW)

Ports:
- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  candidate edge present
- in_ready  out  1  block accepts candidate
- in_dest  in  VW  destination vertex index
- in_dv  in  DW  current distance of destination vertex
- in_w  in  EW  edge weight magnitude
- in_upd  in  1  edge update flag (bit 31 of the packed edge word)
- in_id  in  IW  edge identifier
- in_last  in  1  last candidate of frame
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_dest  out  VW  vertex index of result
- out_id  out  IW  winning edge id
- out_score  out  SW  winning score, SW = max(DW,EW)+1
- out_found  out  1  a real edge won for this vertex
- out_last  out  1  result for vertex NV-1
- err_range  out  1  sticky: candidate with in_dest >= NV seen

## Operation
- Score = in_dv + in_w, zero-extended to SW bits; no saturation, no overflow possible.
- Table entry per vertex: found, upd, score, id. After reset, all found=0.
- Candidate C vs incumbent I, evaluated in order:
  - C non-edge (in_w==0): C loses.
  - I.found==0: C wins.
  - C.upd != I.upd: the one with upd=1 wins.
  - Otherwise: strictly lower score wins. On a tie, I is kept, so the first arrival wins.
- Candidate with in_dest >= NV: dropped, err_range set. err_range is cleared only by reset.
- FSM states:
  - ACCUM: in_ready=1.
  - ACCUM -> FLUSH on accepted candidate with in_last=1.
  - FLUSH: one cycle, in_ready=0, lets the S1 stage commit.
  - FLUSH -> DRAIN unconditionally.
  - DRAIN: in_ready=0. Emit entries 0..NV-1 in order. Each entry is reset to found=0 on its out handshake.
  - DRAIN -> ACCUM on handshake with out_last=1.
- Drain output fields for entries with found=0: out_found=0, out_id=0, out_score=0.
- A frame with no valid edges still drains all NV entries.
- in_last on a dropped (out-of-range) candidate still ends the frame.

## Timing
- Pipeline:
  - Accept at edge t captures the candidate into stage S1.
  - At edge t+1, S1 reads the table, compares, and writes.
  - Back-to-back candidates to the same destination are hazard-free: the table is read combinationally from registers, so S1 always sees the previous commit.
- Throughput: one candidate per cycle in ACCUM.
- Drain timing:
  - Last accepted at edge t: FLUSH during cycle t..t+1, DRAIN entered at edge t+1.
  - out_valid=1 from edge t+2 with entry 0.
  - One result per cycle while out_ready=1.
- Output stability: out_* are registered and held stable while out_valid=1 and out_ready=0.
- Minimum frame-to-frame gap: NV+2 cycles.
- Reset values: in_ready=0 during reset; in_ready=1 in the first cycle after reset_n deasserts. out_valid=0, out_dest=0, out_id=0, out_score=0, out_found=0, out_last=0, err_range=0. All table found=0, S1 empty, FSM=ACCUM.
- Reset mid-frame or mid-drain: everything is discarded immediately (asynchronous); no partial results are emitted afterwards.

## Test plan
- NV=4, single edge d=2, dv=10, w=5, upd=0, id=7, last -> drain: entry 2 found=1, score=15, id=7; entries 0,1,3 found=0; out_last on dest 3.
- Same dest 1, consecutive cycles: (dv=10, w=5, upd=0, id=1), (dv=3, w=4, upd=0, id=2), (dv=2, w=5, upd=0, id=3) -> id=2, score=7 (the tie with id=3 keeps id=2).
- Dest 0: (dv=1, w=1, upd=0, id=1), then (dv=100, w=100, upd=1, id=2) -> id=2, score=200 (update flag beats lower score).
- Dest 3: w=0 candidates only -> found=0. A w=0 candidate after a real winner leaves the winner unchanged.
- in_dest=5 with NV=4 -> dropped, err_range=1 and stays high. With in_last=1, drain still starts at edge+2.
- Drain with out_ready toggling 1,0,0,1 -> outputs held while stalled. The next frame accumulates only after out_last handshake; entries read found=0 unless rewritten. Assert reset_n low mid-drain -> out_valid=0 at once and in_ready=1 after release.
